// File: rtl/bus_arbiter_n.sv
// Round-robin arbiter merging NM masters' read/write pulses onto one single-outstanding slave bus.
// Optional slave-response watchdog: define ARB_TIMEOUT_EN.
module bus_arbiter_n #(
    parameter int NM         = 3,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TMO_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NM-1:0]    m_read_req_i,
    input  logic [NM-1:0]    m_read_w_i,
    input  logic [NM-1:0]    m_read_hw_i,
    input  logic [NM*AW-1:0] m_read_adr_i,
    input  logic [NM-1:0]    m_write_req_i,
    input  logic [NM-1:0]    m_write_w_i,
    input  logic [NM-1:0]    m_write_hw_i,
    input  logic [NM*AW-1:0] m_write_adr_i,
    input  logic [NM*DW-1:0] m_write_data_i,
    output logic [NM-1:0]    m_read_valid_o,
    output logic [NM-1:0]    m_write_finish_o,
    output logic [NM-1:0]    m_timeout_o,
    output logic             read_req_o,
    output logic             write_req_o,
    output logic             read_w_o,
    output logic             read_hw_o,
    output logic             write_w_o,
    output logic             write_hw_o,
    output logic [AW-1:0]    read_adr_o,
    output logic [AW-1:0]    write_adr_o,
    output logic [DW-1:0]    write_data_o,
    input  logic             read_valid_i,
    input  logic             write_finish_i
);
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;
    state_t state_q, state_d;

    logic [PW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick_idx;
    logic          gnt_wr_q, gnt_wr_d, pick_valid, pick_wr, arb_go;
    logic          done_evt, tmo_evt, finish;

    logic [NM-1:0] rd_pend_q, wr_pend_q, rd_set, rd_clr, wr_set, wr_clr;
    logic [NM-1:0] rd_w_s_q, rd_hw_s_q, wr_w_s_q, wr_hw_s_q;
    logic [AW-1:0] rd_adr_s_q [NM];
    logic [AW-1:0] wr_adr_s_q [NM];
    logic [DW-1:0] wr_data_s_q [NM];

    logic [NM-1:0] m_read_valid_q, m_read_valid_d, m_write_finish_q, m_write_finish_d;
    logic [NM-1:0] m_timeout_q, m_timeout_d;
    logic          read_req_q, read_req_d, write_req_q, write_req_d;
    logic          read_w_q, read_w_d, read_hw_q, read_hw_d, write_w_q, write_w_d, write_hw_q, write_hw_d;
    logic [AW-1:0] read_adr_q, read_adr_d, write_adr_q, write_adr_d;
    logic [DW-1:0] write_data_q, write_data_d;

    // Completions of the wrong type, or outside BUSY, are deliberately ignored.
    assign done_evt = (state_q == S_BUSY) && (gnt_wr_q ? write_finish_i : read_valid_i);
    assign finish   = done_evt | tmo_evt;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni || state_q != S_BUSY) tmo_cnt_q <= '0;
        else                              tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end
    assign tmo_evt = (state_q == S_BUSY) && !done_evt && (tmo_cnt_q == CW'(TMO_CYCLES - 1));
`else
    assign tmo_evt = (TMO_CYCLES < 0);
`endif

    // A new pulse on a slot being completed this cycle re-arms it (set wins over clear).
    for (genvar gi = 0; gi < NM; gi++) begin : g_slot
        logic own;
        assign own        = (gnt_q == PW'(gi));
        assign rd_clr[gi] = finish & ~gnt_wr_q & own;
        assign wr_clr[gi] = finish & gnt_wr_q & own;
        assign rd_set[gi] = m_read_req_i[gi] & (~rd_pend_q[gi] | rd_clr[gi]);
        assign wr_set[gi] = m_write_req_i[gi] & (~wr_pend_q[gi] | wr_clr[gi]);

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rd_pend_q[gi] <= 1'b0;
                wr_pend_q[gi] <= 1'b0;
            end else begin
                if (rd_set[gi]) rd_pend_q[gi] <= 1'b1;
                else if (rd_clr[gi]) rd_pend_q[gi] <= 1'b0;
                if (wr_set[gi]) wr_pend_q[gi] <= 1'b1;
                else if (wr_clr[gi]) wr_pend_q[gi] <= 1'b0;
            end
            if (rd_set[gi]) begin
                rd_w_s_q[gi]   <= m_read_w_i[gi];
                rd_hw_s_q[gi]  <= m_read_hw_i[gi];
                rd_adr_s_q[gi] <= m_read_adr_i[gi*AW +: AW];
            end
            if (wr_set[gi]) begin
                wr_w_s_q[gi]    <= m_write_w_i[gi];
                wr_hw_s_q[gi]   <= m_write_hw_i[gi];
                wr_adr_s_q[gi]  <= m_write_adr_i[gi*AW +: AW];
                wr_data_s_q[gi] <= m_write_data_i[gi*DW +: DW];
            end
        end
    end

    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        pick_valid = 1'b0;
        pick_wr    = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        idx        = '0;
        for (int off = 0; off < NM; off++) begin
            sum = {1'b0, rr_q} + (PW+1)'(off);
            if (sum >= (PW+1)'(NM)) sum = sum - (PW+1)'(NM);
            idx = sum[PW-1:0];
            if (!pick_valid && (rd_pend_q[idx] || wr_pend_q[idx])) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
                pick_wr    = !rd_pend_q[idx];
            end
        end
    end

    // Arbitration pauses while a done pulse is out, so back-to-back grants are spaced k+3.
    assign arb_go = (state_q == S_IDLE) && pick_valid && !(|m_read_valid_q) && !(|m_write_finish_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_go) state_d = S_ISSUE;
            S_ISSUE: state_d = S_BUSY;
            S_BUSY:  if (finish) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read_req_d   = arb_go & ~pick_wr;
        write_req_d  = arb_go & pick_wr;
        read_w_d     = read_w_q;
        read_hw_d    = read_hw_q;
        read_adr_d   = read_adr_q;
        write_w_d    = write_w_q;
        write_hw_d   = write_hw_q;
        write_adr_d  = write_adr_q;
        write_data_d = write_data_q;
        if (read_req_d) begin
            read_w_d   = rd_w_s_q[pick_idx];
            read_hw_d  = rd_hw_s_q[pick_idx];
            read_adr_d = rd_adr_s_q[pick_idx];
        end
        if (write_req_d) begin
            write_w_d    = wr_w_s_q[pick_idx];
            write_hw_d   = wr_hw_s_q[pick_idx];
            write_adr_d  = wr_adr_s_q[pick_idx];
            write_data_d = wr_data_s_q[pick_idx];
        end
        m_read_valid_d            = '0;
        m_write_finish_d          = '0;
        m_timeout_d               = '0;
        m_read_valid_d[gnt_q]     = finish & ~gnt_wr_q;
        m_write_finish_d[gnt_q]   = finish & gnt_wr_q;
        m_timeout_d[gnt_q]        = tmo_evt;
        gnt_d    = arb_go ? pick_idx : gnt_q;
        gnt_wr_d = arb_go ? pick_wr : gnt_wr_q;
        rr_d     = rr_q;
        if (finish) rr_d = (gnt_q == PW'(NM - 1)) ? '0 : gnt_q + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            gnt_q            <= '0;
            gnt_wr_q         <= 1'b0;
            rr_q             <= '0;
            m_read_valid_q   <= '0;
            m_write_finish_q <= '0;
            m_timeout_q      <= '0;
            read_req_q       <= 1'b0;
            write_req_q      <= 1'b0;
            read_w_q         <= 1'b0;
            read_hw_q        <= 1'b0;
            write_w_q        <= 1'b0;
            write_hw_q       <= 1'b0;
            read_adr_q       <= '0;
            write_adr_q      <= '0;
            write_data_q     <= '0;
        end else begin
            state_q          <= state_d;
            gnt_q            <= gnt_d;
            gnt_wr_q         <= gnt_wr_d;
            rr_q             <= rr_d;
            m_read_valid_q   <= m_read_valid_d;
            m_write_finish_q <= m_write_finish_d;
            m_timeout_q      <= m_timeout_d;
            read_req_q       <= read_req_d;
            write_req_q      <= write_req_d;
            read_w_q         <= read_w_d;
            read_hw_q        <= read_hw_d;
            write_w_q        <= write_w_d;
            write_hw_q       <= write_hw_d;
            read_adr_q       <= read_adr_d;
            write_adr_q      <= write_adr_d;
            write_data_q     <= write_data_d;
        end
    end

    assign m_read_valid_o   = m_read_valid_q;
    assign m_write_finish_o = m_write_finish_q;
    assign m_timeout_o      = m_timeout_q;
    assign read_req_o       = read_req_q;
    assign write_req_o      = write_req_q;
    assign read_w_o         = read_w_q;
    assign read_hw_o        = read_hw_q;
    assign write_w_o        = write_w_q;
    assign write_hw_o       = write_hw_q;
    assign read_adr_o       = read_adr_q;
    assign write_adr_o      = write_adr_q;
    assign write_data_o     = write_data_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Scoreboard bench for bus_arbiter_n: directed stimulus pushes expected slave requests and
// master done pulses (with cycle stamps); one negedge monitor pops and compares.
module tb_bus_arbiter_n;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NM-1:0]    m_read_req, m_read_w, m_read_hw, m_write_req, m_write_w, m_write_hw;
    logic [NM*AW-1:0] m_read_adr, m_write_adr;
    logic [NM*DW-1:0] m_write_data;
    logic [NM-1:0]    m_read_valid, m_write_finish, m_timeout;
    logic             read_req, write_req, read_w, read_hw, write_w, write_hw;
    logic [AW-1:0]    read_adr, write_adr;
    logic [DW-1:0]    write_data;
    logic             read_valid, write_finish;

    bus_arbiter_n #(.NM(NM), .AW(AW), .DW(DW), .TMO_CYCLES(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_read_req_i(m_read_req), .m_read_w_i(m_read_w), .m_read_hw_i(m_read_hw),
        .m_read_adr_i(m_read_adr),
        .m_write_req_i(m_write_req), .m_write_w_i(m_write_w), .m_write_hw_i(m_write_hw),
        .m_write_adr_i(m_write_adr), .m_write_data_i(m_write_data),
        .m_read_valid_o(m_read_valid), .m_write_finish_o(m_write_finish), .m_timeout_o(m_timeout),
        .read_req_o(read_req), .write_req_o(write_req),
        .read_w_o(read_w), .read_hw_o(read_hw), .write_w_o(write_w), .write_hw_o(write_hw),
        .read_adr_o(read_adr), .write_adr_o(write_adr), .write_data_o(write_data),
        .read_valid_i(read_valid), .write_finish_i(write_finish)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        bit          wr;
        logic [31:0] adr;
        logic [31:0] data;
        bit          w;
        bit          hw;
    } req_t;
    typedef struct {
        int       c;
        logic [2:0] rv;
        logic [2:0] wf;
        logic [2:0] to;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    chk_zero = 0;
    bit    end_req = 0;

    always @(negedge clk) begin : mon
        req_t        er;
        done_t       ed;
        logic [31:0] ga, gd;
        bit          gw, ghw, ok;
        if (chk_zero) begin
            n_cmp++;
            if ({m_read_valid, m_write_finish, m_timeout, read_req, write_req, read_w, read_hw,
                 write_w, write_hw, read_adr, write_adr, write_data} != '0) begin
                n_bad++;
                $display("FAIL zero_outs cyc=%0d got rv=%b wf=%b to=%b rq=%b wq=%b radr=%h wadr=%h wdat=%h required all 0",
                         cyc, m_read_valid, m_write_finish, m_timeout, read_req, write_req, read_adr, write_adr, write_data);
            end else $display("zero_outs ok cyc=%0d", cyc);
        end
        if (read_req || write_req) begin
            n_cmp++;
            ga  = write_req ? write_adr : read_adr;
            gd  = write_req ? write_data : 32'h0;
            gw  = write_req ? write_w : read_w;
            ghw = write_req ? write_hw : read_hw;
            if (req_q.size() == 0) begin
                n_bad++;
                $display("FAIL slave_req cyc=%0d got rd=%b wr=%b adr=%h required no request", cyc, read_req, write_req, ga);
            end else begin
                er = req_q.pop_front();
                ok = (cyc == er.c) && (write_req == er.wr) && (read_req == !er.wr) && (ga == er.adr)
                     && (gw == er.w) && (ghw == er.hw) && (!er.wr || gd == er.data);
                if (!ok) begin
                    n_bad++;
                    $display("FAIL slave_req got cyc=%0d wr=%b adr=%h data=%h w=%b hw=%b required cyc=%0d wr=%b adr=%h data=%h w=%b hw=%b",
                             cyc, write_req, ga, gd, gw, ghw, er.c, er.wr, er.adr, er.data, er.w, er.hw);
                end else $display("slave_req ok cyc=%0d wr=%b adr=%h data=%h", cyc, write_req, ga, gd);
            end
        end
        if (|{m_read_valid, m_write_finish, m_timeout}) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL master_done cyc=%0d got rv=%b wf=%b to=%b required no pulse", cyc, m_read_valid, m_write_finish, m_timeout);
            end else begin
                ed = done_q.pop_front();
                if (cyc != ed.c || m_read_valid != ed.rv || m_write_finish != ed.wf || m_timeout != ed.to) begin
                    n_bad++;
                    $display("FAIL master_done got cyc=%0d rv=%b wf=%b to=%b required cyc=%0d rv=%b wf=%b to=%b",
                             cyc, m_read_valid, m_write_finish, m_timeout, ed.c, ed.rv, ed.wf, ed.to);
                end else $display("master_done ok cyc=%0d rv=%b wf=%b to=%b", cyc, m_read_valid, m_write_finish, m_timeout);
            end
        end
        if (end_req || cyc > 3000) begin
            if (cyc > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL watchdog cyc=%0d got no end of stimulus required end before 3000", cyc);
            end
            n_cmp++;
            if (req_q.size() != 0 || done_q.size() != 0) begin
                n_bad++;
                $display("FAIL leftover got req=%0d done=%0d outstanding required 0/0", req_q.size(), done_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        m_read_req   = '0;
        m_write_req  = '0;
        read_valid   = 1'b0;
        write_finish = 1'b0;
        chk_zero     = 1'b0;
    endtask

    task automatic at(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic rd(input int m, input logic [31:0] adr, input bit w, input bit hw);
        m_read_req[m]         = 1'b1;
        m_read_adr[m*AW +: AW] = adr;
        m_read_w[m]           = w;
        m_read_hw[m]          = hw;
    endtask

    task automatic wr(input int m, input logic [31:0] adr, input logic [31:0] data, input bit w, input bit hw);
        m_write_req[m]           = 1'b1;
        m_write_adr[m*AW +: AW]  = adr;
        m_write_data[m*DW +: DW] = data;
        m_write_w[m]             = w;
        m_write_hw[m]            = hw;
    endtask

    task automatic exp_req(input int c, input bit is_wr, input logic [31:0] adr, input logic [31:0] data,
                           input bit w, input bit hw);
        req_q.push_back('{c, is_wr, adr, data, w, hw});
    endtask

    task automatic exp_done(input int c, input logic [2:0] rv, input logic [2:0] wf, input logic [2:0] to);
        done_q.push_back('{c, rv, wf, to});
    endtask

    initial begin : stim
        int t;
        rst_n = 1'b0;
        m_read_req = '0; m_read_w = '0; m_read_hw = '0; m_read_adr = '0;
        m_write_req = '0; m_write_w = '0; m_write_hw = '0; m_write_adr = '0; m_write_data = '0;
        read_valid = 1'b0; write_finish = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        chk_zero = 1'b1;
        next_cycle();

        // single word read from master 1
        t = cyc;
        exp_req(t + 2, 0, 32'h100, 32'h0, 1, 0);
        exp_done(t + 7, 3'b010, 3'b000, 3'b000);
        rd(1, 32'h100, 1, 0);
        at(t + 6); read_valid = 1'b1;
        at(t + 10);

        // reset while BUSY; the late slave response must vanish
        t = cyc;
        exp_req(t + 2, 0, 32'h200, 32'h0, 0, 1);
        rd(0, 32'h200, 0, 1);
        at(t + 4); rst_n = 1'b0;
        next_cycle(); rst_n = 1'b1; chk_zero = 1'b1;
        at(t + 7); read_valid = 1'b1;
        at(t + 10);
        exp_req(t + 12, 0, 32'h300, 32'h0, 1, 0);
        exp_done(t + 15, 3'b100, 3'b000, 3'b000);
        rd(2, 32'h300, 1, 0);
        at(t + 14); read_valid = 1'b1;
        at(t + 18);

        // three simultaneous writes, rr=0 -> 0,1,2; late re-pulse of pending m2 ignored
        t = cyc;
        exp_req(t + 2,  1, 32'h1000, 32'hA0, 1, 0); exp_done(t + 7,  3'b000, 3'b001, 3'b000);
        exp_req(t + 9,  1, 32'h1004, 32'hA1, 1, 0); exp_done(t + 14, 3'b000, 3'b010, 3'b000);
        exp_req(t + 16, 1, 32'h1008, 32'hA2, 1, 0); exp_done(t + 21, 3'b000, 3'b100, 3'b000);
        wr(0, 32'h1000, 32'hA0, 1, 0); wr(1, 32'h1004, 32'hA1, 1, 0); wr(2, 32'h1008, 32'hA2, 1, 0);
        at(t + 5);  wr(2, 32'h2222, 32'hEE, 0, 1);
        at(t + 6);  write_finish = 1'b1;
        at(t + 13); write_finish = 1'b1;
        at(t + 20); write_finish = 1'b1;
        at(t + 24);
        exp_req(t + 26, 1, 32'h1010, 32'hC0, 1, 0); exp_done(t + 31, 3'b000, 3'b001, 3'b000);
        wr(0, 32'h1010, 32'hC0, 1, 0);
        at(t + 30); write_finish = 1'b1;
        at(t + 34);
        // rr=1 now -> 1,2,0
        exp_req(t + 36, 1, 32'h1104, 32'hB1, 1, 0); exp_done(t + 41, 3'b000, 3'b010, 3'b000);
        exp_req(t + 43, 1, 32'h1108, 32'hB2, 1, 0); exp_done(t + 48, 3'b000, 3'b100, 3'b000);
        exp_req(t + 50, 1, 32'h1100, 32'hB0, 1, 0); exp_done(t + 55, 3'b000, 3'b001, 3'b000);
        wr(0, 32'h1100, 32'hB0, 1, 0); wr(1, 32'h1104, 32'hB1, 1, 0); wr(2, 32'h1108, 32'hB2, 1, 0);
        at(t + 40); write_finish = 1'b1;
        at(t + 47); write_finish = 1'b1;
        at(t + 54); write_finish = 1'b1;
        at(t + 58);

        // master 0 read+write together: read first; stray completions ignored
        t = cyc;
        exp_req(t + 2, 0, 32'h40, 32'h0, 0, 1);        exp_done(t + 6,  3'b001, 3'b000, 3'b000);
        exp_req(t + 8, 1, 32'h44, 32'hDEADBEEF, 0, 0); exp_done(t + 11, 3'b000, 3'b001, 3'b000);
        rd(0, 32'h40, 0, 1); wr(0, 32'h44, 32'hDEADBEEF, 0, 0);
        at(t + 3);  write_finish = 1'b1;
        at(t + 5);  read_valid = 1'b1;
        at(t + 7);  read_valid = 1'b1;
        at(t + 8);  write_finish = 1'b1;
        at(t + 10); write_finish = 1'b1;
        at(t + 14);

        // master 2 re-arms its read in the completion cycle
        t = cyc;
        exp_req(t + 2, 0, 32'h500, 32'h0, 1, 0); exp_done(t + 7,  3'b100, 3'b000, 3'b000);
        exp_req(t + 9, 0, 32'h504, 32'h0, 0, 1); exp_done(t + 13, 3'b100, 3'b000, 3'b000);
        rd(2, 32'h500, 1, 0);
        at(t + 6);  read_valid = 1'b1; rd(2, 32'h504, 0, 1);
        at(t + 12); read_valid = 1'b1;
        at(t + 16);

        // unresponsive slave
        t = cyc;
        exp_req(t + 2, 0, 32'h600, 32'h0, 1, 0);
        rd(1, 32'h600, 1, 0);
`ifdef ARB_TIMEOUT_EN
        exp_done(t + 19, 3'b010, 3'b000, 3'b010);
        at(t + 25); read_valid = 1'b1;
        at(t + 30);
`else
        exp_done(t + 41, 3'b010, 3'b000, 3'b000);
        at(t + 40); read_valid = 1'b1;
        at(t + 45);
`endif
        end_req = 1'b1;
    end

endmodule
